// File: rtl/subw_serial.sv
// Bit-serial subtractor: o0 = i0-i1 (op=0) or i1-i0 (op=1), chunk bits per cycle, LSB chunk first.
// Latency width/chunk+1 cycles start->done; one result per width/chunk+2 cycles back-to-back.
// No queueing: start while busy is dropped. Optional port borrow_out under SUBW_SERIAL_BORROW_OUT_EN.
module subw_serial #(
    parameter int width = 16,
    parameter int chunk = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] i0,
    input  logic [width-1:0] i1,
    input  logic             op,
    input  logic             pred,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] o0,
    output logic             o0_enable
`ifdef SUBW_SERIAL_BORROW_OUT_EN
    ,
    output logic             borrow_out
`endif
);

    localparam int NCH = width / chunk;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [width-1:0] a_q, a_d;       // minuend, shifted right one chunk per RUN cycle
    logic [width-1:0] b_q, b_d;       // subtrahend, shifted alongside
    logic [width-1:0] res_q, res_d;   // result assembled from the top down
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pred_q, pred_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [width-1:0] o0_q, o0_d;
    logic             o0_en_q, o0_en_d;
`ifdef SUBW_SERIAL_BORROW_OUT_EN
    logic             borrow_out_q, borrow_out_d;
`endif

    // One chunk of the difference; the extra top bit is the borrow into the next chunk.
    logic [chunk:0]       diff;
    logic [width+chunk-1:0] res_cat;

    // Chunk subtractor and next-state logic for the whole datapath.
    always_comb begin
        diff = {1'b0, a_q[chunk-1:0]} - {1'b0, b_q[chunk-1:0]} - {{chunk{1'b0}}, borrow_q};
        // Concatenation keeps the shift legal even when chunk == width.
        res_cat = {diff[chunk-1:0], res_q};

        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        pred_d   = pred_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        o0_d     = o0_q;
        o0_en_d  = o0_en_q;
`ifdef SUBW_SERIAL_BORROW_OUT_EN
        borrow_out_d = borrow_out_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = op ? i1 : i0;
                    b_d      = op ? i0 : i1;
                    pred_d   = pred;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_d      = a_q >> chunk;
                b_d      = b_q >> chunk;
                res_d    = res_cat[width+chunk-1:chunk];
                borrow_d = diff[chunk];
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                o0_d    = res_q;
                o0_en_d = pred_q;
`ifdef SUBW_SERIAL_BORROW_OUT_EN
                borrow_out_d = borrow_q;
`endif
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any operation immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            pred_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            o0_q     <= '0;
            o0_en_q  <= 1'b0;
`ifdef SUBW_SERIAL_BORROW_OUT_EN
            borrow_out_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            pred_q   <= pred_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            o0_q     <= o0_d;
            o0_en_q  <= o0_en_d;
`ifdef SUBW_SERIAL_BORROW_OUT_EN
            borrow_out_q <= borrow_out_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign o0        = o0_q;
    assign o0_enable = o0_en_q;
`ifdef SUBW_SERIAL_BORROW_OUT_EN
    assign borrow_out = borrow_out_q;
`endif

endmodule

// File: tb/tb_subw_serial.sv
// Directed + randomized bench for subw_serial (16/4 and 8/8 instances).
// Expected results come from plain modular arithmetic on the applied operands.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_subw_serial;

    logic        clk;
    logic        reset;
    logic [15:0] i0, i1;
    logic        op, pred, start;
    logic        busy, done, o0_enable;
    logic [15:0] o0;
`ifdef SUBW_SERIAL_BORROW_OUT_EN
    logic        borrow_out;
`endif

    logic [7:0]  a8, b8, o8;
    logic        op8, pred8, start8, busy8, done8, en8;
`ifdef SUBW_SERIAL_BORROW_OUT_EN
    logic        borrow8;
`endif

    int vectors    = 0;
    int miscompares = 0;

    subw_serial #(.width(16), .chunk(4)) dut (
        .clk(clk), .reset(reset), .i0(i0), .i1(i1), .op(op), .pred(pred),
        .start(start), .busy(busy), .done(done), .o0(o0), .o0_enable(o0_enable)
`ifdef SUBW_SERIAL_BORROW_OUT_EN
        , .borrow_out(borrow_out)
`endif
    );

    subw_serial #(.width(8), .chunk(8)) dut8 (
        .clk(clk), .reset(reset), .i0(a8), .i1(b8), .op(op8), .pred(pred8),
        .start(start8), .busy(busy8), .done(done8), .o0(o8), .o0_enable(en8)
`ifdef SUBW_SERIAL_BORROW_OUT_EN
        , .borrow_out(borrow8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation from a falling edge and check it at the done pulse.
    // Returns at the falling edge on which done is seen, so a following call
    // places its start in the cycle right after done.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic o, input logic p);
        logic [15:0] exp;
        logic        bexp;
        int          lat;
        exp  = o ? (b - a) : (a - b);
        bexp = o ? (b < a) : (a < b);
        i0 = a; i1 = b; op = o; pred = p; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, 32'd5);
        chk({tag, "_o0"}, {16'd0, o0}, {16'd0, exp});
        chk({tag, "_en"}, {31'd0, o0_enable}, {31'd0, p});
`ifdef SUBW_SERIAL_BORROW_OUT_EN
        chk({tag, "_bout"}, {31'd0, borrow_out}, {31'd0, bexp});
`else
        if (bexp === 1'bx) $display("unexpected unknown borrow in %s", tag);
`endif
    endtask

    initial begin
        int          lat;
        int          ndone;
        logic [15:0] cap;
        logic [15:0] ra, rb;

        reset = 1'b1;
        i0 = '0; i1 = '0; op = 1'b0; pred = 1'b0; start = 1'b0;
        a8 = '0; b8 = '0; op8 = 1'b0; pred8 = 1'b0; start8 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_o0", {16'd0, o0}, 32'd0);
        chk("rst_en", {31'd0, o0_enable}, 32'd0);
        chk("rst8_o0", {24'd0, o8}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic subtract, then single-cycle done pulse.
        run_op("r032", 16'h1234, 16'h0234, 1'b0, 1'b1);
        @(negedge clk);
        chk("r032_pulse", {31'd0, done}, 32'd0);

        // Underflow wraps; pred=0 still computes o0.
        run_op("r033", 16'h0000, 16'h0001, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("r033_hold_o0", {16'd0, o0}, 32'h0000FFFF);
        chk("r033_hold_en", {31'd0, o0_enable}, 32'd0);

        // Reverse subtract with a stray start in the 2nd RUN cycle.
        i0 = 16'h0005; i1 = 16'h0009; op = 1'b1; pred = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; lat = 0; cap = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin
                    lat = k;
                    cap = o0;
                end
            end
            if (k == 1) begin
                i0 = 16'hAAAA; i1 = 16'h1111; op = 1'b0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        chk("r034_ndone", ndone, 32'd1);
        chk("r034_lat", lat, 32'd5);
        chk("r034_o0", {16'd0, cap}, 32'h00000004);

        // Asynchronous reset in the 3rd RUN cycle aborts the operation.
        i0 = 16'h0100; i1 = 16'h0001; op = 1'b0; pred = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("r035_busy", {31'd0, busy}, 32'd0);
        chk("r035_o0", {16'd0, o0}, 32'd0);
        chk("r035_done", {31'd0, done}, 32'd0);
        #1 reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("r035_nodone", ndone, 32'd0);
        run_op("r035_after", 16'h4321, 16'h1111, 1'b0, 1'b1);
        @(negedge clk);

        // Back-to-back random operations, each started the cycle after done.
        for (int n = 0; n < 100; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (n == 0) begin
                ra = 16'hFFFF; rb = 16'h0000;
            end
            run_op("b2b", ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        @(negedge clk);

        // Single-chunk build: one RUN cycle, latency 2.
        a8 = 8'h80; b8 = 8'h01; op8 = 1'b0; pred8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (done8 !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("r037_lat", lat, 32'd2);
        chk("r037_o0", {24'd0, o8}, 32'h0000007F);
        chk("r037_en", {31'd0, en8}, 32'd1);
`ifdef SUBW_SERIAL_BORROW_OUT_EN
        chk("r037_bout", {31'd0, borrow8}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
